// File: rtl/gpio_led_ctrl.sv
// LED pattern sequencer with static, blink and chase modes and a programmable step prescaler.
// Optional PWM brightness gating when GPIO_LED_CTRL_PWM_EN is defined (adds duty_i).
module gpio_led_ctrl #(
  parameter int unsigned GPIO_NUM  = 32,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 load_i,
  input  logic                 stop_i,
  input  logic                 en_i,
  input  logic [1:0]           mode_i,
  input  logic [GPIO_NUM-1:0]  pattern_i,
  input  logic [DIV_WIDTH-1:0] div_i,
`ifdef GPIO_LED_CTRL_PWM_EN
  input  logic [7:0]           duty_i,
`endif
  output logic [GPIO_NUM-1:0]  led_o,
  output logic                 tick_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  localparam logic [1:0] ModeStatic = 2'b00;
  localparam logic [1:0] ModeBlink  = 2'b01;
  localparam logic [1:0] ModeLeft   = 2'b10;
  localparam logic [1:0] ModeRight  = 2'b11;

  state_e               state_q, state_d;
  logic [GPIO_NUM-1:0]  pat_q, pat_d;
  logic [1:0]           mode_q, mode_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic                 tick_q, tick_d;
  logic [GPIO_NUM-1:0]  led_q, led_d;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    mode_d  = mode_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    if (stop_i) begin
      state_d = StIdle;
      pat_d   = '0;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (load_i) begin
      // A load coincident with a step discards that step.
      pat_d   = pattern_i;
      mode_d  = mode_i;
      div_d   = div_i;
      cnt_d   = '0;
      phase_d = 1'b1;
      state_d = en_i ? StRun : StPause;
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          if (!en_i) begin
            state_d = StPause;
          end else if (cnt_q == div_q) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            unique case (mode_q)
              ModeStatic: ;
              ModeBlink:  phase_d = ~phase_q;
              ModeLeft:   pat_d = {pat_q[GPIO_NUM-2:0], pat_q[GPIO_NUM-1]};
              ModeRight:  pat_d = {pat_q[0], pat_q[GPIO_NUM-1:1]};
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StPause: begin
          if (en_i) state_d = StRun;
        end
        default: state_d = StIdle;
      endcase
    end

    // LED drive is registered from next-state values so it lines up with tick.
    if (state_d == StIdle) begin
      led_d = '0;
    end else if (mode_d == ModeBlink) begin
      led_d = phase_d ? pat_d : '0;
    end else begin
      led_d = pat_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      pat_q   <= '0;
      mode_q  <= ModeStatic;
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
    end
  end

`ifdef GPIO_LED_CTRL_PWM_EN
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_on;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_on    = pwm_cnt_q < duty_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign led_o = led_q & {GPIO_NUM{pwm_on}};
`else
  assign led_o = led_q;
`endif

  assign tick_o = tick_q;
  assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Directed self-checking bench for gpio_led_ctrl (GPIO_NUM=8, DIV_WIDTH=16).
module tb_gpio_led_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        load_i, stop_i, en_i;
  logic [1:0]  mode_i;
  logic [7:0]  pattern_i;
  logic [15:0] div_i;
  logic [7:0]  led_o;
  logic        tick_o, busy_o;
`ifdef GPIO_LED_CTRL_PWM_EN
  logic [7:0]  duty_i;
`endif

  int n_cmp = 0;
  int n_err = 0;

  gpio_led_ctrl #(.GPIO_NUM(8), .DIV_WIDTH(16)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .load_i    (load_i),
    .stop_i    (stop_i),
    .en_i      (en_i),
    .mode_i    (mode_i),
    .pattern_i (pattern_i),
    .div_i     (div_i),
`ifdef GPIO_LED_CTRL_PWM_EN
    .duty_i    (duty_i),
`endif
    .led_o     (led_o),
    .tick_o    (tick_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_load(input logic [7:0] pat, input logic [1:0] mode, input logic [15:0] div);
    pattern_i = pat;
    mode_i    = mode;
    div_i     = div;
    load_i    = 1'b1;
    cyc();
    load_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    load_i = 1'b0; stop_i = 1'b0; en_i = 1'b0;
    mode_i = 2'b00; pattern_i = 8'h00; div_i = 16'd0;
`ifdef GPIO_LED_CTRL_PWM_EN
    duty_i = 8'd255;
`endif
    #1;
    n_cmp++; if (led_o !== 8'h00) begin n_err++; $display("FAIL reset_led got %h want 00", led_o); end
    n_cmp++; if (tick_o !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b want 0", tick_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    cyc(); cyc();
    rst_n_i = 1'b1;
    en_i = 1'b1;
    pattern_i = 8'hFF;
    repeat (3) cyc();
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL idle_en_busy got %b want 0", busy_o); end
    n_cmp++; if (led_o !== 8'h00) begin n_err++; $display("FAIL idle_en_led got %h want 00", led_o); end
  endtask

  task automatic test_chase_left();
    logic [7:0] exp_led;
    en_i = 1'b1;
    do_load(8'h81, 2'b10, 16'd3);
    n_cmp++; if (led_o !== 8'h81) begin n_err++; $display("FAIL cl_first got %h want 81", led_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL cl_busy got %b want 1", busy_o); end
    n_cmp++; if (tick_o !== 1'b0) begin n_err++; $display("FAIL cl_tick0 got %b want 0", tick_o); end
    for (int k = 1; k <= 8; k++) begin
      cyc();
      exp_led = (k < 4) ? 8'h81 : ((k < 8) ? 8'h03 : 8'h06);
      n_cmp++;
      if (led_o !== exp_led) begin
        n_err++; $display("FAIL cl_led k=%0d got %h want %h", k, led_o, exp_led);
      end
      n_cmp++;
      if (tick_o !== (k % 4 == 0)) begin
        n_err++; $display("FAIL cl_tick k=%0d got %b want %b", k, tick_o, (k % 4 == 0));
      end
    end
  endtask

  task automatic test_blink();
    en_i = 1'b1;
    do_load(8'hA5, 2'b01, 16'd0);
    n_cmp++; if (led_o !== 8'hA5) begin n_err++; $display("FAIL bl_first got %h want a5", led_o); end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      n_cmp++;
      if (led_o !== ((k % 2 == 1) ? 8'h00 : 8'hA5)) begin
        n_err++; $display("FAIL bl_led k=%0d got %h want %h", k, led_o,
                          ((k % 2 == 1) ? 8'h00 : 8'hA5));
      end
      n_cmp++;
      if (tick_o !== 1'b1) begin n_err++; $display("FAIL bl_tick k=%0d got %b want 1", k, tick_o); end
    end
  endtask

  task automatic test_pause();
    en_i = 1'b1;
    do_load(8'h01, 2'b11, 16'd1);
    cyc();  // cnt 0 -> 1, no step yet
    n_cmp++; if (led_o !== 8'h01) begin n_err++; $display("FAIL pr_pre got %h want 01", led_o); end
    en_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      n_cmp++;
      if (led_o !== 8'h01 || tick_o !== 1'b0 || busy_o !== 1'b1) begin
        n_err++; $display("FAIL pr_hold k=%0d got led=%h tick=%b busy=%b want 01/0/1",
                          k, led_o, tick_o, busy_o);
      end
    end
    en_i = 1'b1;
    cyc();  // back to RUN
    n_cmp++;
    if (led_o !== 8'h01 || tick_o !== 1'b0) begin
      n_err++; $display("FAIL pr_resume got led=%h tick=%b want 01/0", led_o, tick_o);
    end
    cyc();  // frozen cnt==1 == div -> step
    n_cmp++;
    if (led_o !== 8'h80 || tick_o !== 1'b1) begin
      n_err++; $display("FAIL pr_step got led=%h tick=%b want 80/1", led_o, tick_o);
    end
  endtask

  task automatic test_load_on_step();
    en_i = 1'b1;
    do_load(8'h81, 2'b10, 16'd0);
    cyc();
    n_cmp++; if (led_o !== 8'h03) begin n_err++; $display("FAIL ls_run got %h want 03", led_o); end
    do_load(8'h0F, 2'b10, 16'd0);
    n_cmp++;
    if (led_o !== 8'h0F || tick_o !== 1'b0) begin
      n_err++; $display("FAIL ls_load got led=%h tick=%b want 0f/0", led_o, tick_o);
    end
  endtask

  task automatic test_stop_load();
    en_i = 1'b1;
    do_load(8'h3C, 2'b00, 16'd2);
    cyc();
    stop_i = 1'b1;
    do_load(8'hFF, 2'b00, 16'd2);
    stop_i = 1'b0;
    n_cmp++;
    if (led_o !== 8'h00 || busy_o !== 1'b0 || tick_o !== 1'b0) begin
      n_err++; $display("FAIL sl_idle got led=%h busy=%b tick=%b want 00/0/0", led_o, busy_o, tick_o);
    end
  endtask

  task automatic test_async_reset();
    en_i = 1'b1;
    do_load(8'hA5, 2'b01, 16'd0);
    cyc();
    #3 rst_n_i = 1'b0;
    #1;
    n_cmp++;
    if (led_o !== 8'h00 || tick_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL ar_async got led=%h tick=%b busy=%b want 00/0/0", led_o, tick_o, busy_o);
    end
    cyc();
    rst_n_i = 1'b1;
    repeat (4) cyc();
    n_cmp++;
    if (led_o !== 8'h00 || tick_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL ar_stay got led=%h tick=%b busy=%b want 00/0/0", led_o, tick_o, busy_o);
    end
    do_load(8'h42, 2'b00, 16'd0);
    n_cmp++; if (led_o !== 8'h42) begin n_err++; $display("FAIL ar_reload got %h want 42", led_o); end
  endtask

`ifdef GPIO_LED_CTRL_PWM_EN
  task automatic test_pwm();
    int hi;
    int bad;
    en_i = 1'b1;
    duty_i = 8'd64;
    do_load(8'hFF, 2'b00, 16'd0);
    hi = 0; bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (led_o[0]) hi++;
      if (led_o !== 8'h00 && led_o !== 8'hFF) bad++;
      cyc();
    end
    n_cmp++; if (hi !== 64) begin n_err++; $display("FAIL pwm64_count got %0d want 64", hi); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL pwm64_bits got %0d odd cycles want 0", bad); end
    duty_i = 8'd0;
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      if (led_o !== 8'h00) hi++;
      cyc();
    end
    n_cmp++; if (hi !== 0) begin n_err++; $display("FAIL pwm0_count got %0d want 0", hi); end
    duty_i = 8'd255;
  endtask
`endif

  initial begin
    test_reset();
    test_chase_left();
    test_blink();
    test_pause();
    test_load_on_step();
    test_stop_load();
    test_async_reset();
`ifdef GPIO_LED_CTRL_PWM_EN
    test_pwm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_led_ctrl.md
GPIO_LED_CTRL -- requirements
Module: gpio_led_ctrl

Interface
REQ-001 SHALL have parameter GPIO_NUM, default 32, number of LED lines driven.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, width of the step prescaler.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load_i, input, 1, pulse that captures pattern_i, mode_i and div_i and starts the sequence.
REQ-006 SHALL have port stop_i, input, 1, pulse that returns to IDLE.
REQ-007 SHALL have port en_i, input, 1; 0 pauses a running sequence.
REQ-008 SHALL have port mode_i, input, 2: 00 static, 01 blink, 10 chase-left, 11 chase-right.
REQ-009 SHALL have port pattern_i, input, GPIO_NUM, initial LED pattern.
REQ-010 SHALL have port div_i, input, DIV_WIDTH, step period minus one, in clk_i cycles.
REQ-011 SHALL have port led_o, output, GPIO_NUM, LED drive, 1 = lit.
REQ-012 SHALL have port tick_o, output, 1, one-cycle pulse per sequence step.
REQ-013 SHALL have port busy_o, output, 1, high when state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE.
REQ-015 SHALL, on load_i=1 in any state, capture pat_q<=pattern_i, mode_q<=mode_i, div_q<=div_i, cnt<=0, phase<=1, and enter RUN if en_i=1, else PAUSE.
REQ-016 SHALL give stop_i priority over load_i: stop_i=1 forces IDLE, clears pat_q, cnt, phase.
REQ-017 SHALL, in RUN with en_i=0, enter PAUSE with cnt, pat_q, phase frozen; in PAUSE with en_i=1, return to RUN and resume counting from the frozen cnt.
REQ-018 SHALL, in RUN, increment cnt each cycle; when cnt==div_q, set cnt<=0 and perform one step; div_q=0 steps every cycle.
REQ-019 SHALL perform a step as follows: static, no change; blink, phase toggles; chase-left, pat_q rotates left 1 with bit GPIO_NUM-1 wrapping to bit 0; chase-right, rotates right 1 with bit 0 wrapping to bit GPIO_NUM-1.
REQ-020 SHALL register tick_o high for exactly the cycle after a step, coincident with the updated led_o.
REQ-021 SHALL drive led_o = pat_q in static/chase modes, pat_q when phase=1 else 0 in blink mode, and 0 in IDLE.
REQ-022 SHALL show the loaded pattern on led_o in the first cycle after load_i (1-cycle latency).
REQ-023 SHALL, on load_i coincident with a step, discard the step: load wins, tick_o stays 0.
REQ-024 SHALL ignore en_i in IDLE and ignore mode_i/pattern_i/div_i changes unless load_i=1.

Reset
REQ-025 SHALL, on rst_n_i=0, immediately set state IDLE, led_o=0, tick_o=0, busy_o=0, cnt=0, pat_q=0, mode_q=00, div_q=0, phase=0.
REQ-026 SHALL, on reset mid-sequence, abandon it; a new load_i is required after release.

Configuration
REQ-027 SHALL, with GPIO_LED_CTRL_PWM_EN defined, add input duty_i[7:0] and a free-running 8-bit pwm counter (reset 0), and gate led_o with (pwm_cnt < duty_i), giving duty_i/256 brightness, where duty_i=0 means always dark.
REQ-028 SHALL, without GPIO_LED_CTRL_PWM_EN, have no duty_i port and no pwm counter, with led_o per REQ-021 ungated.

Verification (GPIO_NUM=8, DIV_WIDTH=16)
REQ-029 SHALL cover: chase-left, pattern 8'h81, div 3, en 1 -> led_o 8'h81 then 8'h03 after 4 cycles, 8'h06 after 8, tick_o one cycle per step.
REQ-030 SHALL cover: blink, pattern 8'hA5, div 0 -> led_o alternates 8'hA5/8'h00 every cycle, tick_o constantly high.
REQ-031 SHALL cover: chase-right, pattern 8'h01, div 1, en dropped for 5 cycles mid-count -> led_o holds, step resumes from the frozen cnt, next pattern 8'h80.
REQ-032 SHALL cover: load_i and stop_i in the same cycle during RUN -> IDLE, led_o=0, busy_o=0.
REQ-033 SHALL cover: rst_n_i low for 1 cycle mid-sequence -> all outputs 0 asynchronously; they stay 0 until load_i.
REQ-034 SHALL cover: with GPIO_LED_CTRL_PWM_EN, static 8'hFF, duty_i 64 -> each led_o bit high 64 of every 256 cycles; duty_i 0 -> led_o always 0.
